// File: rtl/alu_seq.sv
// alu_seq: registered ALU with persistent {T,V,C,N,Z} flags, carry chaining, compares
// and iterative shifts/rotates. Define ALU_SEQ_BARREL_SHIFT_EN for single-cycle shifts.
module alu_seq #(
    parameter int WIDTH = 20,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [13:0]      instruction,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [4:0]       flags,
    input  logic             flags_load,
    input  logic [4:0]       flags_in
);

    localparam logic [13:0] OP_NOT   = 14'h0A7;
    localparam logic [13:0] OP_OR    = 14'h0D1;
    localparam logic [13:0] OP_AND   = 14'h0BC;
    localparam logic [13:0] OP_XOR   = 14'h0E6;
    localparam logic [13:0] OP_SHFTR = 14'h0FB;
    localparam logic [13:0] OP_SHFTL = 14'h110;
    localparam logic [13:0] OP_ROTR  = 14'h125;
    localparam logic [13:0] OP_ROTL  = 14'h13A;
    localparam logic [13:0] OP_INC   = 14'h164;
    localparam logic [13:0] OP_DEC   = 14'h179;
    localparam logic [13:0] OP_ADD   = 14'h18E;
    localparam logic [13:0] OP_ADDC  = 14'h1A3;
    localparam logic [13:0] OP_SUB   = 14'h1B8;
    localparam logic [13:0] OP_SUBC  = 14'h1CD;
    localparam logic [13:0] OP_EQ    = 14'h1E2;
    localparam logic [13:0] OP_GT    = 14'h1F7;
    localparam logic [13:0] OP_LT    = 14'h20C;
    localparam logic [13:0] OP_GET   = 14'h221;
    localparam logic [13:0] OP_LET   = 14'h236;

    localparam int F_Z = 0;
    localparam int F_N = 1;
    localparam int F_C = 2;
    localparam int F_V = 3;
    localparam int F_T = 4;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // kind[1] = rotate, kind[0] = left
    localparam logic [1:0] K_SHR = 2'b00;
    localparam logic [1:0] K_SHL = 2'b01;
    localparam logic [1:0] K_ROR = 2'b10;
    localparam logic [1:0] K_ROL = 2'b11;

    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [4:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       kind_q, kind_d;
    logic             set_zn;
    logic             accept;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    // INC/DEC reuse the add/subtract path with B forced to 1; ADDC/SUBC pull in C.
    logic             use_one, use_c;
    logic [WIDTH-1:0] arith_b;
    logic [WIDTH:0]   ext_sum, ext_dif;
    logic             add_v, sub_v;

    assign use_one = (instruction == OP_INC) || (instruction == OP_DEC);
    assign use_c   = (instruction == OP_ADDC) || (instruction == OP_SUBC);
    assign arith_b = use_one ? WIDTH'(1) : b;
    assign ext_sum = {1'b0, a} + {1'b0, arith_b} + {{WIDTH{1'b0}}, use_c & flags_q[F_C]};
    assign ext_dif = {1'b0, a} - {1'b0, arith_b} - {{WIDTH{1'b0}}, use_c & flags_q[F_C]};
    assign add_v   = (a[WIDTH-1] == arith_b[WIDTH-1]) && (ext_sum[WIDTH-1] != a[WIDTH-1]);
    assign sub_v   = (a[WIDTH-1] != arith_b[WIDTH-1]) && (ext_dif[WIDTH-1] != a[WIDTH-1]);

    logic             is_shift;
    logic [1:0]       op_kind;
    logic [CNT_W-1:0] op_k;

    always_comb begin
        is_shift = 1'b1;
        op_kind  = K_SHR;
        case (instruction)
            OP_SHFTR: op_kind = K_SHR;
            OP_SHFTL: op_kind = K_SHL;
            OP_ROTR:  op_kind = K_ROR;
            OP_ROTL:  op_kind = K_ROL;
            default:  is_shift = 1'b0;
        endcase
    end

    assign op_k = op_kind[1] ? CNT_W'(b % W_VAL)
                             : ((b >= W_VAL) ? CNT_W'(WIDTH) : CNT_W'(b));

    logic [WIDTH-1:0] step_work;
    logic             step_c;

    always_comb begin
        case (kind_q)
            K_SHR:   begin step_work = work_q >> 1; step_c = work_q[0]; end
            K_SHL:   begin step_work = work_q << 1; step_c = work_q[WIDTH-1]; end
            K_ROR:   begin step_work = {work_q[0], work_q[WIDTH-1:1]}; step_c = work_q[0]; end
            default: begin step_work = {work_q[WIDTH-2:0], work_q[WIDTH-1]}; step_c = work_q[WIDTH-1]; end
        endcase
    end

`ifdef ALU_SEQ_BARREL_SHIFT_EN
    logic [WIDTH-1:0]   bar_res, bar_tmp;
    logic [2*WIDTH-1:0] bar_dbl;
    logic               bar_c;

    // The last bit out of a k-bit shift is the edge bit after shifting by k-1.
    always_comb begin
        bar_res = '0;
        bar_tmp = '0;
        bar_dbl = '0;
        bar_c   = 1'b0;
        case (op_kind)
            K_SHR: begin
                bar_res = a >> op_k;
                bar_tmp = a >> (op_k - CNT_W'(1));
                bar_c   = bar_tmp[0];
            end
            K_SHL: begin
                bar_res = a << op_k;
                bar_tmp = a << (op_k - CNT_W'(1));
                bar_c   = bar_tmp[WIDTH-1];
            end
            K_ROR: begin
                bar_dbl = {a, a} >> op_k;
                bar_res = bar_dbl[WIDTH-1:0];
                bar_c   = bar_res[WIDTH-1];
            end
            default: begin
                bar_dbl = {a, a} << op_k;
                bar_res = bar_dbl[2*WIDTH-1:WIDTH];
                bar_c   = bar_res[0];
            end
        endcase
    end
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        flags_d     = flags_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        kind_d      = kind_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        set_zn      = 1'b0;

        if (state_q == SHIFT) begin
            work_d = step_work;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d       = IDLE;
                out_valid_d   = 1'b1;
                result_d      = step_work;
                flags_d[F_C]  = step_c;
                set_zn        = 1'b1;
            end
        end else if (accept) begin
            out_valid_d = 1'b1;
            set_zn      = 1'b1;
            if (is_shift) begin
                if (op_k == '0) begin
                    result_d = a;
                end else begin
`ifdef ALU_SEQ_BARREL_SHIFT_EN
                    result_d     = bar_res;
                    flags_d[F_C] = bar_c;
`else
                    out_valid_d = 1'b0;
                    set_zn      = 1'b0;
                    work_d      = a;
                    cnt_d       = op_k;
                    kind_d      = op_kind;
                    state_d     = SHIFT;
`endif
                end
            end else begin
                case (instruction)
                    OP_NOT: result_d = ~a;
                    OP_OR:  result_d = a | b;
                    OP_AND: result_d = a & b;
                    OP_XOR: result_d = a ^ b;
                    OP_INC, OP_ADD, OP_ADDC: begin
                        result_d     = ext_sum[WIDTH-1:0];
                        flags_d[F_C] = ext_sum[WIDTH];
                        flags_d[F_V] = add_v;
                    end
                    OP_DEC, OP_SUB, OP_SUBC: begin
                        result_d     = ext_dif[WIDTH-1:0];
                        flags_d[F_C] = ext_dif[WIDTH];
                        flags_d[F_V] = sub_v;
                    end
                    OP_EQ:  begin set_zn = 1'b0; flags_d[F_T] = (a == b); end
                    OP_GT:  begin set_zn = 1'b0; flags_d[F_T] = (a > b);  end
                    OP_LT:  begin set_zn = 1'b0; flags_d[F_T] = (a < b);  end
                    OP_GET: begin set_zn = 1'b0; flags_d[F_T] = (a >= b); end
                    OP_LET: begin set_zn = 1'b0; flags_d[F_T] = (a <= b); end
                    default: begin
                        set_zn   = 1'b0;
                        err_d    = 1'b1;
                        result_d = '0;
                    end
                endcase
            end
        end

        if (set_zn) begin
            flags_d[F_Z] = (result_d == '0);
            flags_d[F_N] = result_d[WIDTH-1];
        end
        // Context restore wins over whatever the op would have written.
        if (flags_load) flags_d = flags_in;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
            work_q      <= '0;
            cnt_q       <= '0;
            kind_q      <= K_SHR;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            kind_q      <= kind_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign err       = err_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (iterative shift build).
module tb_alu_seq;

    localparam int W = 20;

    localparam logic [13:0] OP_NOT   = 14'h0A7;
    localparam logic [13:0] OP_OR    = 14'h0D1;
    localparam logic [13:0] OP_AND   = 14'h0BC;
    localparam logic [13:0] OP_XOR   = 14'h0E6;
    localparam logic [13:0] OP_SHFTR = 14'h0FB;
    localparam logic [13:0] OP_SHFTL = 14'h110;
    localparam logic [13:0] OP_ROTR  = 14'h125;
    localparam logic [13:0] OP_ROTL  = 14'h13A;
    localparam logic [13:0] OP_INC   = 14'h164;
    localparam logic [13:0] OP_DEC   = 14'h179;
    localparam logic [13:0] OP_ADD   = 14'h18E;
    localparam logic [13:0] OP_ADDC  = 14'h1A3;
    localparam logic [13:0] OP_SUB   = 14'h1B8;
    localparam logic [13:0] OP_SUBC  = 14'h1CD;
    localparam logic [13:0] OP_EQ    = 14'h1E2;
    localparam logic [13:0] OP_GT    = 14'h1F7;
    localparam logic [13:0] OP_LT    = 14'h20C;
    localparam logic [13:0] OP_GET   = 14'h221;
    localparam logic [13:0] OP_LET   = 14'h236;

    logic         clk, rst, in_valid, in_ready, out_valid, err, flags_load;
    logic [13:0]  instruction;
    logic [W-1:0] a, b, result;
    logic [4:0]   flags, flags_in;
    int           total = 0;
    int           bad = 0;

    alu_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .a(a), .b(b), .out_valid(out_valid),
        .result(result), .err(err), .flags(flags), .flags_load(flags_load),
        .flags_in(flags_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    // Offer one op at a negedge; returns #1 after the accept edge.
    task automatic drive(input logic [13:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         input logic fl_ld = 1'b0, input logic [4:0] fl_v = 5'b0);
        @(negedge clk);
        in_valid = 1'b1; instruction = op; a = aa; b = bb;
        flags_load = fl_ld; flags_in = fl_v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; flags_load = 1'b0;
    endtask

    // Bounded wait for out_valid after a multi-cycle accept.
    task automatic wait_done(output int cyc, output int low);
        cyc = 0;
        low = in_ready ? 0 : 1;
        @(negedge clk);
        in_valid = 1'b0; flags_load = 1'b0;
        while (cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) break;
            if (!in_ready) low++;
        end
    endtask

    task automatic load_flags(input logic [4:0] v);
        @(negedge clk);
        in_valid = 1'b0; flags_load = 1'b1; flags_in = v;
        @(posedge clk);
        #1;
        total++; if (flags !== v) begin bad++; $display("FAIL flags_load got=%b want=%b", flags, v); end
        @(negedge clk);
        flags_load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
        total++; if (result !== 20'h00000) begin bad++; $display("FAIL rst_result got=%h want=00000", result); end
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL rst_flags got=%b want=00000", flags); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add();
        drive(OP_ADD, 20'hFFFFF, 20'h00001);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b want=1", out_valid); end
        total++; if (result !== 20'h00000) begin bad++; $display("FAIL add_result got=%h want=00000", result); end
        total++; if (flags !== 5'b00101) begin bad++; $display("FAIL add_flags got=%b want=00101", flags); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL add_err got=%b want=0", err); end
        idle();
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_pulse got=%b want=0", out_valid); end
    endtask

    task automatic test_carry_chain();
        drive(OP_ADD, 20'hFFFFF, 20'h00001);
        drive(OP_ADDC, 20'h00005, 20'h00006);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addc_valid got=%b want=1", out_valid); end
        total++; if (result !== 20'h0000C) begin bad++; $display("FAIL addc_result got=%h want=0000c", result); end
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL addc_flags got=%b want=00000", flags); end
        drive(OP_ADD, 20'hFFFFF, 20'h00001);
        drive(OP_SUBC, 20'h00003, 20'h00003);
        total++; if (result !== 20'hFFFFF) begin bad++; $display("FAIL subc_result got=%h want=fffff", result); end
        total++; if (flags !== 5'b00110) begin bad++; $display("FAIL subc_flags got=%b want=00110", flags); end
        idle();
    endtask

    task automatic test_arith_flags();
        drive(OP_ADD, 20'h7FFFF, 20'h00001);
        total++; if (result !== 20'h80000) begin bad++; $display("FAIL addv_result got=%h want=80000", result); end
        total++; if (flags !== 5'b01010) begin bad++; $display("FAIL addv_flags got=%b want=01010", flags); end
        drive(OP_SUB, 20'h00000, 20'h00001);
        total++; if (result !== 20'hFFFFF) begin bad++; $display("FAIL sub_result got=%h want=fffff", result); end
        total++; if (flags !== 5'b00110) begin bad++; $display("FAIL sub_flags got=%b want=00110", flags); end
        drive(OP_INC, 20'hFFFFF, 20'h12345);
        total++; if (result !== 20'h00000) begin bad++; $display("FAIL inc_result got=%h want=00000", result); end
        total++; if (flags !== 5'b00101) begin bad++; $display("FAIL inc_flags got=%b want=00101", flags); end
        drive(OP_DEC, 20'h80000, 20'h54321);
        total++; if (result !== 20'h7FFFF) begin bad++; $display("FAIL dec_result got=%h want=7ffff", result); end
        total++; if (flags !== 5'b01000) begin bad++; $display("FAIL dec_flags got=%b want=01000", flags); end
        idle();
    endtask

    task automatic test_back_to_back();
        drive(OP_AND, 20'hF0F0F, 20'h0FF00);
        total++; if (result !== 20'h00F00) begin bad++; $display("FAIL and_result got=%h want=00f00", result); end
        total++; if (flags !== 5'b01000) begin bad++; $display("FAIL and_flags got=%b want=01000", flags); end
        drive(OP_XOR, 20'hAAAAA, 20'hAAAAA);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL xor_valid got=%b want=1", out_valid); end
        total++; if (result !== 20'h00000) begin bad++; $display("FAIL xor_result got=%h want=00000", result); end
        total++; if (flags !== 5'b01001) begin bad++; $display("FAIL xor_flags got=%b want=01001", flags); end
        drive(OP_NOT, 20'h0000F, 20'h00000);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL not_ready got=%b want=1", in_ready); end
        total++; if (result !== 20'hFFFF0) begin bad++; $display("FAIL not_result got=%h want=ffff0", result); end
        total++; if (flags !== 5'b01010) begin bad++; $display("FAIL not_flags got=%b want=01010", flags); end
        drive(OP_OR, 20'h12340, 20'h00005);
        total++; if (result !== 20'h12345) begin bad++; $display("FAIL or_result got=%h want=12345", result); end
        total++; if (flags !== 5'b01000) begin bad++; $display("FAIL or_flags got=%b want=01000", flags); end
        idle();
    endtask

    task automatic test_rotate();
        int cyc, low;
        load_flags(5'b11100);
        drive(OP_ROTL, 20'h80001, 20'd4);
        wait_done(cyc, low);
        total++; if (cyc !== 4) begin bad++; $display("FAIL rotl_latency got=%0d want=4", cyc); end
        total++; if (low !== 4) begin bad++; $display("FAIL rotl_not_ready got=%0d want=4", low); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rotl_valid got=%b want=1", out_valid); end
        total++; if (result !== 20'h00018) begin bad++; $display("FAIL rotl_result got=%h want=00018", result); end
        total++; if (flags !== 5'b11000) begin bad++; $display("FAIL rotl_flags got=%b want=11000", flags); end
        drive(OP_ROTR, 20'h00001, 20'd21);
        wait_done(cyc, low);
        total++; if (cyc !== 1) begin bad++; $display("FAIL rotr_latency got=%0d want=1", cyc); end
        total++; if (result !== 20'h80000) begin bad++; $display("FAIL rotr_result got=%h want=80000", result); end
        total++; if (flags !== 5'b11110) begin bad++; $display("FAIL rotr_flags got=%b want=11110", flags); end
    endtask

    task automatic test_shift();
        int cyc, low;
        drive(OP_SHFTR, 20'hABCDE, 20'd25);
        wait_done(cyc, low);
        total++; if (cyc !== 20) begin bad++; $display("FAIL shftr_latency got=%0d want=20", cyc); end
        total++; if (low !== 20) begin bad++; $display("FAIL shftr_not_ready got=%0d want=20", low); end
        total++; if (result !== 20'h00000) begin bad++; $display("FAIL shftr_result got=%h want=00000", result); end
        total++; if (flags !== 5'b11101) begin bad++; $display("FAIL shftr_flags got=%b want=11101", flags); end
        drive(OP_SHFTL, 20'h12345, 20'd0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL shftl0_valid got=%b want=1", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL shftl0_ready got=%b want=1", in_ready); end
        total++; if (result !== 20'h12345) begin bad++; $display("FAIL shftl0_result got=%h want=12345", result); end
        total++; if (flags !== 5'b11100) begin bad++; $display("FAIL shftl0_flags got=%b want=11100", flags); end
        idle();
        drive(OP_SHFTL, 20'h40001, 20'd2);
        wait_done(cyc, low);
        total++; if (cyc !== 2) begin bad++; $display("FAIL shftl2_latency got=%0d want=2", cyc); end
        total++; if (result !== 20'h00004) begin bad++; $display("FAIL shftl2_result got=%h want=00004", result); end
        total++; if (flags !== 5'b11100) begin bad++; $display("FAIL shftl2_flags got=%b want=11100", flags); end
    endtask

    task automatic test_compare();
        load_flags(5'b00000);
        drive(OP_LT, 20'd2, 20'd7);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lt_valid got=%b want=1", out_valid); end
        total++; if (result !== 20'h00004) begin bad++; $display("FAIL lt_result got=%h want=00004", result); end
        total++; if (flags !== 5'b10000) begin bad++; $display("FAIL lt_flags got=%b want=10000", flags); end
        drive(OP_GT, 20'd2, 20'd7);
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL gt_flags got=%b want=00000", flags); end
        drive(OP_GET, 20'd7, 20'd7);
        total++; if (flags !== 5'b10000) begin bad++; $display("FAIL get_flags got=%b want=10000", flags); end
        drive(OP_LET, 20'd8, 20'd7);
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL let_flags got=%b want=00000", flags); end
        load_flags(5'b00000);
        drive(OP_EQ, 20'd9, 20'd9, 1'b1, 5'b00000);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL eq_valid got=%b want=1", out_valid); end
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL eq_load_flags got=%b want=00000", flags); end
        total++; if (result !== 20'h00004) begin bad++; $display("FAIL eq_result got=%h want=00004", result); end
        idle();
    endtask

    task automatic test_reset_abort();
        int pulses;
        load_flags(5'b10101);
        drive(OP_SHFTL, 20'h00001, 20'd10);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_mid_valid got=%b want=0", out_valid); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", out_valid); end
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL abort_flags got=%b want=00000", flags); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", in_ready); end
        total++; if (result !== 20'h00000) begin bad++; $display("FAIL abort_result got=%h want=00000", result); end
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        total++; if (pulses !== 0) begin bad++; $display("FAIL abort_late_valid got=%0d want=0", pulses); end
    endtask

    task automatic test_illegal();
        drive(OP_OR, 20'h12340, 20'h00005);
        total++; if (result !== 20'h12345) begin bad++; $display("FAIL pre_ill_result got=%h want=12345", result); end
        drive(14'h3FFF, 20'h00005, 20'h00006);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ill_valid got=%b want=1", out_valid); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL ill_err got=%b want=1", err); end
        total++; if (result !== 20'h00000) begin bad++; $display("FAIL ill_result got=%h want=00000", result); end
        total++; if (flags !== 5'b00000) begin bad++; $display("FAIL ill_flags got=%b want=00000", flags); end
        drive(OP_AND, 20'hFFFFF, 20'h00001);
        total++; if (err !== 1'b0) begin bad++; $display("FAIL post_ill_err got=%b want=0", err); end
        total++; if (result !== 20'h00001) begin bad++; $display("FAIL post_ill_result got=%h want=00001", result); end
        idle();
        @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", out_valid); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; instruction = '0; a = '0; b = '0;
        flags_load = 1'b0; flags_in = '0;
        test_reset();
        test_add();
        test_carry_chain();
        test_arith_flags();
        test_back_to_back();
        test_rotate();
        test_shift();
        test_compare();
        test_reset_abort();
        test_illegal();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
